// File: rtl/lut_table_loader.sv
// Runtime-loadable LUT neuron: streams a truth table into distributed RAM, then serves 1-cycle lookups.
// Optional readback port enabled by defining LUT_LOADER_READBACK_EN.
module lut_table_loader #(
    parameter int IN_BITS    = 8,
    parameter int OUT_BITS   = 2,
    parameter int FIELD_BITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [OUT_BITS-1:0] cfg_data,
    input  logic                cfg_last,
    input  logic [IN_BITS-1:0]  M0,
    input  logic                in_valid,
    output logic [OUT_BITS-1:0] M1,
    output logic                out_valid,
    output logic                loaded,
    output logic                load_err
`ifdef LUT_LOADER_READBACK_EN
    ,
    input  logic [IN_BITS-1:0]  rb_addr,
    output logic [OUT_BITS-1:0] rb_data
`endif
);
    localparam int NUM_FIELDS = IN_BITS / FIELD_BITS;
    localparam int DEPTH      = 1 << IN_BITS;

    typedef enum logic [1:0] {LOAD, DONE, ERR} state_t;

    state_t              state_q, state_d;
    logic [IN_BITS-1:0]  k_q, k_d;
    logic                cfg_ready_q, cfg_ready_d;
    logic                loaded_q, loaded_d;
    logic                load_err_q, load_err_d;
    logic [OUT_BITS-1:0] m1_q, m1_d;
    logic                out_valid_q, out_valid_d;
    logic [OUT_BITS-1:0] mem [DEPTH];
    logic [IN_BITS-1:0]  waddr;
    logic                xfer;
    logic                k_at_max;

    // Stream order runs the lowest input field fastest, but that field sits in the top bits of M0.
    for (genvar f = 0; f < NUM_FIELDS; f++) begin : g_rev
        assign waddr[f*FIELD_BITS +: FIELD_BITS] = k_q[(NUM_FIELDS-1-f)*FIELD_BITS +: FIELD_BITS];
    end

    assign xfer     = cfg_valid && cfg_ready_q && !rst;
    assign k_at_max = (k_q == {IN_BITS{1'b1}});

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        cfg_ready_d = cfg_ready_q;
        loaded_d    = loaded_q;
        load_err_d  = load_err_q;
        case (state_q)
            LOAD: begin
                if (xfer) begin
                    k_d = k_q + IN_BITS'(1);
                    if (cfg_last && k_at_max) begin
                        state_d     = DONE;
                        cfg_ready_d = 1'b0;
                        loaded_d    = 1'b1;
                    end else if (cfg_last || k_at_max) begin
                        state_d     = ERR;
                        cfg_ready_d = 1'b0;
                        load_err_d  = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        // Gating on loaded_q keeps stale or partial tables invisible to the datapath.
        m1_d        = loaded_q ? mem[M0] : '0;
        out_valid_d = in_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD;
            k_q         <= '0;
            cfg_ready_q <= 1'b1;
            loaded_q    <= 1'b0;
            load_err_q  <= 1'b0;
            m1_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            cfg_ready_q <= cfg_ready_d;
            loaded_q    <= loaded_d;
            load_err_q  <= load_err_d;
            m1_q        <= m1_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Table storage is never reset; a new load simply overwrites it.
    always_ff @(posedge clk) begin
        if (xfer) mem[waddr] <= cfg_data;
    end

`ifdef LUT_LOADER_READBACK_EN
    logic [OUT_BITS-1:0] rb_data_q, rb_data_d;
    always_comb rb_data_d = mem[rb_addr];
    always_ff @(posedge clk) begin
        if (rst) rb_data_q <= '0;
        else     rb_data_q <= rb_data_d;
    end
    assign rb_data = rb_data_q;
`endif

    assign cfg_ready = cfg_ready_q;
    assign loaded    = loaded_q;
    assign load_err  = load_err_q;
    assign M1        = m1_q;
    assign out_valid = out_valid_q;
endmodule
